cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Producer end of the common data bus (CDB) whose tag broadcast wakes operands in every reservation station. It collects completion packets from `N_PORTS` functional units, buffers each in a small per-port FIFO, and grants one packet per cycle. The granted packet is driven as a registered, single-cycle CDB broadcast of tag, data and ROB index. It sits between the execute-stage units and the reservation stations, PRF writeback and ROB.

## Interface
- `N_PORTS`, 4, number of functional-unit producer ports (≥2)
- `TAG_W`, 7, physical-register tag width
- `DATA_W`, 32, result data width
- `ROB_W`, 5, ROB index width
- `FIFO_DEPTH`, 2, per-port buffer entries (power of two, ≥2)

- `clk_i`  in  1  clock; all state updates on its rising edge
- `rst_i`  in  1  reset, asynchronous, active-high
- `recover_i`  in  1  misprediction flush, synchronous
- `fu_valid_i`  in  N_PORTS  per-port packet valid
- `fu_ready_o`  out  N_PORTS  per-port FIFO can accept
- `fu_tag_i`  in  N_PORTS*TAG_W  packed tags; port p occupies bits [p*TAG_W +: TAG_W]
- `fu_data_i`  in  N_PORTS*DATA_W  packed results
- `fu_rob_i`  in  N_PORTS*ROB_W  packed ROB indices
- `cdb_valid_o`  out  1  broadcast valid, one cycle per packet
- `cdb_tag_o`  out  TAG_W  broadcast tag
- `cdb_data_o`  out  DATA_W  broadcast data
- `cdb_rob_o`  out  ROB_W  broadcast ROB index

## Operation
- **Per-port FIFO.**
  - Each port has its own FIFO with head/tail pointers that wrap modulo `FIFO_DEPTH` and a count of width `$clog2(FIFO_DEPTH)+1`.
  - `fu_ready_o[p] = (count_p != FIFO_DEPTH) && !recover_i && !rst_i`.
  - Push when `fu_valid_i[p] && fu_ready_o[p]`.
- **Full port.** Readiness uses the count before this cycle's pop. A full port is therefore not ready even in the cycle it is popped; there is no pass-through.
- **Arbitration.**
  - The request vector is the set of non-empty FIFOs.
  - Exactly one grant per cycle when any request exists. The granted FIFO head is popped and loaded into the output registers.
- **Output registers.**
  - `cdb_valid_o` is 1 for the cycle after each grant and 0 otherwise.
  - Tag, data and ROB outputs are forced to 0 whenever `cdb_valid_o` is 0.
  - The CDB has no backpressure: every broadcast is consumed.
- **Tag 0.** Tag 0 is not filtered. Such packets are broadcast unchanged.
- **Simultaneous push and pop on one port.** Both occur in the same cycle and the count is unchanged. Packet order within a port is strictly FIFO.
- **Recover.** In a cycle with `recover_i` high, at the next edge:
  - all counts and pointers clear;
  - `cdb_valid_o` and the output payload clear;
  - the arbitration pointer returns to 0;
  - pushes presented that cycle are dropped, because ready is 0.
- **Reset.** Asynchronous reset produces the same state as recover. Reset values of the outputs are: `cdb_valid_o`=0, `cdb_tag_o`/`cdb_data_o`/`cdb_rob_o`=0, `fu_ready_o`=0 while `rst_i` is high, and all-ones in the first cycle after deassertion.

## Timing
- **Latency.**
  - A packet accepted at edge E into an empty FIFO is granted in the cycle after E.
  - It appears on the CDB (`cdb_valid_o`=1) after edge E+1, one cycle.
  - Minimum handshake-to-broadcast latency is 2 edges.
- **Throughput.** One broadcast per cycle aggregate. A single port streaming back-to-back sustains one packet per cycle when `FIFO_DEPTH` ≥ 2 and it is the only requester.
- **Reset mid-operation.** Reset takes effect immediately. All buffered packets are lost and no partial broadcast is emitted.
- **Recover concurrent with a grant.** The grant is discarded and no broadcast occurs the following cycle.

## Configuration
- **Macro:** `CDB_ARB_ROUND_ROBIN_EN`.
- **Defined (round-robin).**
  - A priority pointer `rr_ptr` (width `$clog2(N_PORTS)`) starts at 0.
  - The grant goes to the first requester at or after `rr_ptr`, searching upward with wrap.
  - After a grant to port g, `rr_ptr` becomes `(g+1) mod N_PORTS`. It is unchanged when there is no grant.
- **Undefined (fixed priority).** The lowest-numbered requesting port always wins, and no pointer state exists.
- Every other behaviour is identical in both builds.

## Test plan
- **Reset values:** assert `rst_i` mid-stream with 2 packets buffered → outputs 0 and `fu_ready_o`=0 during reset. After release: `fu_ready_o`=4'b1111, and no broadcast appears for 3 cycles.
- **Single packet:** port 2 sends tag 7'h15, data 32'hDEADBEEF, rob 5'd9 at edge E → `cdb_valid_o`=1 with exactly those values for one cycle after E+1. Payload is 0 before and after.
- **Full and ordering:** port 0 pushes 3 packets back-to-back while ports 1–3 stream continuously.
  - Port 0's third push is held off: `fu_ready_o[0]`=0 once count reaches 2.
  - Port 0's broadcasts are in push order.
  - No packet is lost or duplicated.
- **Fairness (macro defined):** all 4 ports always non-empty → grants cycle 0,1,2,3,0,… with each port granted once every 4 cycles.
- **Fairness (macro undefined):** same stimulus → port 0 is granted every cycle until its FIFO drains. Ports 1–3 wait.
- **Recover:** 5 packets buffered across ports and `recover_i` pulsed for one cycle concurrent with a grant → no broadcast in the following cycle and all counts 0. A new packet pushed after recover is broadcast with 2-edge latency.

Source files
------------

// File: rtl/cdb_arbiter.sv
// CDB producer: per-port completion FIFOs, one grant per cycle, registered broadcast.
// Define CDB_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed priority (port 0 highest).

module cdb_arb_fifo #(
  parameter int W     = 44,
  parameter int DEPTH = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         recover_i,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;

  // Payload storage needs no reset; validity lives entirely in count.
  always_ff @(posedge clk_i)
    if (push) mem[tail] <= wdata;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (recover_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign rdata = mem[head];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
endmodule

module cdb_arbiter #(
  parameter int N_PORTS    = 4,
  parameter int TAG_W      = 7,
  parameter int DATA_W     = 32,
  parameter int ROB_W      = 5,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      recover_i,
  input  logic [N_PORTS-1:0]        fu_valid_i,
  output logic [N_PORTS-1:0]        fu_ready_o,
  input  logic [N_PORTS*TAG_W-1:0]  fu_tag_i,
  input  logic [N_PORTS*DATA_W-1:0] fu_data_i,
  input  logic [N_PORTS*ROB_W-1:0]  fu_rob_i,
  output logic                      cdb_valid_o,
  output logic [TAG_W-1:0]          cdb_tag_o,
  output logic [DATA_W-1:0]         cdb_data_o,
  output logic [ROB_W-1:0]          cdb_rob_o
);
  localparam int PKT_W = TAG_W + DATA_W + ROB_W;
  localparam int IDX_W = $clog2(N_PORTS);

  logic [N_PORTS-1:0][PKT_W-1:0] wpkt, hpkt;
  logic [N_PORTS-1:0]            full, empty, push, pop, req;
  logic                          gnt_any;
  logic [IDX_W-1:0]              gnt_idx, cand;
  logic [PKT_W-1:0]              out_pkt;

  for (genvar p = 0; p < N_PORTS; p++) begin : g_port
    assign wpkt[p] = {fu_tag_i[p*TAG_W +: TAG_W], fu_data_i[p*DATA_W +: DATA_W],
                      fu_rob_i[p*ROB_W +: ROB_W]};
    // Ready looks at the pre-pop count, so a full port never passes through.
    assign fu_ready_o[p] = !full[p] && !recover_i && !rst_i;
    assign push[p]       = fu_valid_i[p] && fu_ready_o[p];
    assign pop[p]        = gnt_any && (gnt_idx == IDX_W'(p));
    assign req[p]        = !empty[p];

    cdb_arb_fifo #(.W(PKT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .recover_i (recover_i),
      .push      (push[p]),
      .pop       (pop[p]),
      .wdata     (wpkt[p]),
      .rdata     (hpkt[p]),
      .full      (full[p]),
      .empty     (empty[p])
    );
  end

`ifdef CDB_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] rr_ptr;
  int               rr_sum;

  // Scan downward so the last hit is the first requester at/after rr_ptr.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    rr_sum  = 0;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      rr_sum = int'(rr_ptr) + i;
      if (rr_sum >= N_PORTS) rr_sum = rr_sum - N_PORTS;
      cand = IDX_W'(rr_sum);
      if (req[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                rr_ptr <= '0;
    else if (recover_i)       rr_ptr <= '0;
    else if (gnt_any)
      rr_ptr <= (gnt_idx == IDX_W'(N_PORTS - 1)) ? '0 : gnt_idx + IDX_W'(1);
  end
`else
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      cand = IDX_W'(i);
      if (req[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end
`endif

  // A grant coinciding with recover is dropped along with the FIFO contents.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cdb_valid_o <= 1'b0;
      out_pkt     <= '0;
    end else if (recover_i || !gnt_any) begin
      cdb_valid_o <= 1'b0;
      out_pkt     <= '0;
    end else begin
      cdb_valid_o <= 1'b1;
      out_pkt     <= hpkt[gnt_idx];
    end
  end

  assign {cdb_tag_o, cdb_data_o, cdb_rob_o} = out_pkt;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed table, corner sequences and random traffic against a queue model.
module tb_cdb_arbiter;
  localparam int N = 4, TW = 7, DW = 32, RW = 5, D = 2, PW = TW + DW + RW;

  logic              clk = 1'b0, rst_i = 1'b1, recover_i = 1'b0;
  logic [N-1:0]      fu_valid_i = '0, fu_ready_o;
  logic [N*TW-1:0]   fu_tag_i = '0;
  logic [N*DW-1:0]   fu_data_i = '0;
  logic [N*RW-1:0]   fu_rob_i = '0;
  logic              cdb_valid_o;
  logic [TW-1:0]     cdb_tag_o;
  logic [DW-1:0]     cdb_data_o;
  logic [RW-1:0]     cdb_rob_o;

  cdb_arbiter #(.N_PORTS(N), .TAG_W(TW), .DATA_W(DW), .ROB_W(RW), .FIFO_DEPTH(D)) dut (
    .clk_i(clk), .rst_i(rst_i), .recover_i(recover_i),
    .fu_valid_i(fu_valid_i), .fu_ready_o(fu_ready_o),
    .fu_tag_i(fu_tag_i), .fu_data_i(fu_data_i), .fu_rob_i(fu_rob_i),
    .cdb_valid_o(cdb_valid_o), .cdb_tag_o(cdb_tag_o),
    .cdb_data_o(cdb_data_o), .cdb_rob_o(cdb_rob_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  int n_tests = 0, n_fail = 0;

  // Reference model: one queue per port, a priority index, expected broadcast.
  logic [PW-1:0] q [N][$];
  int            rr = 0;
  logic          exp_v = 1'b0;
  logic [PW-1:0] exp_pkt = '0;
  logic [TW-1:0] tin [N];
  logic [DW-1:0] din [N];
  logic [RW-1:0] rin [N];
  logic [N-1:0]  rdy_seen;

  typedef struct {
    logic [N-1:0]  v;
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
    logic [RW-1:0] rob;
    logic          ev;
    logic [TW-1:0] et;
    logic [DW-1:0] ed;
    logic [RW-1:0] er;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int p = 0; p < N; p++) q[p].delete();
    rr      = 0;
    exp_v   = 1'b0;
    exp_pkt = '0;
  endtask

  // Drive one cycle's inputs, predict, cross the posedge, compare at the negedge.
  task automatic tick(input logic [N-1:0] v, input logic rec);
    logic [N-1:0] rm;
    int g;
    for (int p = 0; p < N; p++) begin
      fu_tag_i[p*TW +: TW]  = tin[p];
      fu_data_i[p*DW +: DW] = din[p];
      fu_rob_i[p*RW +: RW]  = rin[p];
    end
    fu_valid_i = v;
    recover_i  = rec;
    #1;
    for (int p = 0; p < N; p++) rm[p] = (q[p].size() < D) && !rec;
    rdy_seen = fu_ready_o;
    chk("ready", 64'(fu_ready_o), 64'(rm));
    if (rec) model_clear();
    else begin
      g = -1;
`ifdef CDB_ARB_ROUND_ROBIN_EN
      for (int i = 0; i < N; i++)
        if (g < 0 && q[(rr + i) % N].size() > 0) g = (rr + i) % N;
`else
      for (int i = 0; i < N; i++)
        if (g < 0 && q[i].size() > 0) g = i;
`endif
      if (g >= 0) begin
        exp_v   = 1'b1;
        exp_pkt = q[g].pop_front();
        rr      = (g + 1) % N;
      end else begin
        exp_v   = 1'b0;
        exp_pkt = '0;
      end
      for (int p = 0; p < N; p++)
        if (v[p] && rm[p]) q[p].push_back({tin[p], din[p], rin[p]});
    end
    @(negedge clk);
    chk("cdb_valid", 64'(cdb_valid_o), 64'(exp_v));
    chk("cdb_tag",   64'(cdb_tag_o),   64'(exp_pkt[PW-1 -: TW]));
    chk("cdb_data",  64'(cdb_data_o),  64'(exp_pkt[RW +: DW]));
    chk("cdb_rob",   64'(cdb_rob_o),   64'(exp_pkt[RW-1:0]));
  endtask

  initial begin
    for (int p = 0; p < N; p++) begin tin[p] = '0; din[p] = '0; rin[p] = '0; end
    tbl[0] = '{4'b0100, 7'h15, 32'hDEADBEEF, 5'd9, 1'b0, 7'h00, 32'h0, 5'd0};
    tbl[1] = '{4'b0000, 7'h00, 32'h0,        5'd0, 1'b1, 7'h15, 32'hDEADBEEF, 5'd9};
    tbl[2] = '{4'b0000, 7'h00, 32'h0,        5'd0, 1'b0, 7'h00, 32'h0, 5'd0};
    tbl[3] = '{4'b0010, 7'h01, 32'h11,       5'd1, 1'b0, 7'h00, 32'h0, 5'd0};
    tbl[4] = '{4'b0010, 7'h02, 32'h22,       5'd2, 1'b1, 7'h01, 32'h11, 5'd1};
    tbl[5] = '{4'b0000, 7'h00, 32'h0,        5'd0, 1'b1, 7'h02, 32'h22, 5'd2};
    tbl[6] = '{4'b0000, 7'h00, 32'h0,        5'd0, 1'b0, 7'h00, 32'h0, 5'd0};
    tbl[7] = '{4'b1000, 7'h00, 32'h5,        5'd3, 1'b0, 7'h00, 32'h0, 5'd0};
    tbl[8] = '{4'b0000, 7'h00, 32'h0,        5'd0, 1'b1, 7'h00, 32'h5, 5'd3};
    tbl[9] = '{4'b0000, 7'h00, 32'h0,        5'd0, 1'b0, 7'h00, 32'h0, 5'd0};

    // Power-on reset
    #1;
    chk("rst_ready", 64'(fu_ready_o), 64'(0));
    chk("rst_valid", 64'(cdb_valid_o), 64'(0));
    chk("rst_data",  64'(cdb_data_o), 64'(0));
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    model_clear();
    #1 chk("post_rst_ready", 64'(fu_ready_o), 64'(4'hF));

    // Directed table: single packet, back-to-back on one port, tag 0
    for (int s = 0; s < 10; s++) begin
      for (int p = 0; p < N; p++) begin
        tin[p] = tbl[s].tag; din[p] = tbl[s].data; rin[p] = tbl[s].rob;
      end
      tick(tbl[s].v, 1'b0);
      chk("tbl_valid", 64'(cdb_valid_o), 64'(tbl[s].ev));
      chk("tbl_tag",   64'(cdb_tag_o),   64'(tbl[s].et));
      chk("tbl_data",  64'(cdb_data_o),  64'(tbl[s].ed));
      chk("tbl_rob",   64'(cdb_rob_o),   64'(tbl[s].er));
    end

    // Fairness / full port: all ports stream continuously
    tick('0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      for (int p = 0; p < N; p++) begin
        tin[p] = {2'(p), 5'(k)}; din[p] = $urandom; rin[p] = 5'(k);
      end
      tick(4'hF, 1'b0);
`ifdef CDB_ARB_ROUND_ROBIN_EN
      if (k == 3) chk("full_rdy0", 64'(rdy_seen[0]), 64'(0));
      if (k >= 1) chk("fair_port", 64'(cdb_tag_o[TW-1 -: 2]), 64'((k - 1) % N));
`else
      if (k == 3) chk("full_rdy0", 64'(rdy_seen[0]), 64'(1));
      if (k >= 1) chk("fair_port", 64'(cdb_tag_o[TW-1 -: 2]), 64'(0));
`endif
      if (k >= 1) chk("fair_valid", 64'(cdb_valid_o), 64'(1));
    end
    repeat (10) tick('0, 1'b0);

    // Recover concurrent with a grant, 5 packets buffered
    tick('0, 1'b1);
    for (int p = 0; p < N; p++) begin tin[p] = {2'(p), 5'h10}; din[p] = $urandom; rin[p] = 5'(p); end
    tick(4'hF, 1'b0);
    for (int p = 0; p < N; p++) begin tin[p] = {2'(p), 5'h11}; din[p] = $urandom; end
    tick(4'b0110, 1'b0);
    chk("rec_pre_valid", 64'(cdb_valid_o), 64'(1));
    chk("rec_pre_port",  64'(cdb_tag_o), 64'(7'h10));
    tick('0, 1'b1);
    chk("rec_ready", 64'(rdy_seen), 64'(0));
    chk("rec_valid", 64'(cdb_valid_o), 64'(0));
    tick('0, 1'b0);
    chk("rec_empty", 64'(rdy_seen), 64'(4'hF));
    chk("rec_idle",  64'(cdb_valid_o), 64'(0));
    tin[3] = 7'h33; din[3] = 32'h12345678; rin[3] = 5'd7;
    tick(4'b1000, 1'b0);
    chk("rec_lat1", 64'(cdb_valid_o), 64'(0));
    tick('0, 1'b0);
    chk("rec_lat2_valid", 64'(cdb_valid_o), 64'(1));
    chk("rec_lat2_tag",   64'(cdb_tag_o), 64'(7'h33));
    chk("rec_lat2_data",  64'(cdb_data_o), 64'(32'h12345678));
    tick('0, 1'b0);

    // Reset mid-stream while broadcasting with 2 packets buffered
    tin[0] = 7'h41; din[0] = 32'hA1; rin[0] = 5'd1;
    tick(4'b0001, 1'b0);
    tin[0] = 7'h42; din[0] = 32'hA2; rin[0] = 5'd2;
    tin[1] = 7'h43; din[1] = 32'hA3; rin[1] = 5'd3;
    tick(4'b0011, 1'b0);
    fu_valid_i = '0;
    #2 rst_i = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(cdb_valid_o), 64'(0));
    chk("mid_rst_tag",   64'(cdb_tag_o), 64'(0));
    chk("mid_rst_data",  64'(cdb_data_o), 64'(0));
    chk("mid_rst_rob",   64'(cdb_rob_o), 64'(0));
    chk("mid_rst_ready", 64'(fu_ready_o), 64'(0));
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    model_clear();
    #1 chk("mid_rst_release_ready", 64'(fu_ready_o), 64'(4'hF));
    for (int i = 0; i < 3; i++) begin
      tick('0, 1'b0);
      chk("mid_rst_quiet", 64'(cdb_valid_o), 64'(0));
    end

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < N; p++) begin
        tin[p] = 7'($urandom); din[p] = $urandom; rin[p] = 5'($urandom);
      end
      tick(4'($urandom), ($urandom_range(0, 39) == 0));
    end
    repeat (10) tick('0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
